text_line_renderer: RTL and testbench

Parametrised successor to the fixed 10-glyph header generators. It holds a writable character buffer of NUM_CHARS font keys and renders them, one glyph per cycle, through a single shared font ROM port into a registered row-major pixel map. The pixel map is double-buffered, so the VGA/overlay logic always sees a stable image. An optional blinking highlight inverts one character, for example the cursor or the active-effect arrow.

---
 rtl/text_line_renderer.sv | 122 ++++++++++++
 tb/tb_text_line_renderer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_renderer.sv
// text_line_renderer
//   Holds a line of NUM_CHARS font keys and renders them, one glyph per cycle,
//   through a shared combinational font ROM into a double-buffered pixel map.
//   A blinking highlight can invert one character (cursor / active marker).
//
// Ports
//   Clk, Reset   : clock, synchronous active-high reset
//   wr_en/addr/key : write one buffer slot (addr 0 = leftmost; out-of-range ignored)
//   start        : request a render (pulse or level)
//   hl_en/hl_pos : highlight enable and highlighted slot
//   rom_key      : key presented to the font ROM
//   rom_data     : glyph from the ROM, row 0 in MSBs, leftmost pixel = row MSB
//   busy         : render in progress
//   done         : one-cycle pulse when pixel_map updates
//   blink_phase  : current highlight phase
//   pixel_map    : rendered line; row r at [(GLYPH_H-r)*LW-1 -: LW], char 0 in row MSBs
module text_line_renderer #(
  parameter int              NUM_CHARS    = 10,
  parameter int              GLYPH_W      = 12,
  parameter int              GLYPH_H      = 12,
  parameter int              KEY_W        = 5,
  parameter logic [KEY_W-1:0] BLANK_KEY   = {KEY_W{1'b1}},
  parameter int              BLINK_FRAMES = 16,
  localparam int             AW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
  input  logic                                   Clk,
  input  logic                                   Reset,
  input  logic                                   wr_en,
  input  logic [AW-1:0]                          wr_addr,
  input  logic [KEY_W-1:0]                       wr_key,
  input  logic                                   start,
  input  logic                                   hl_en,
  input  logic [AW-1:0]                          hl_pos,
  output logic [KEY_W-1:0]                       rom_key,
  input  logic [GLYPH_W*GLYPH_H-1:0]             rom_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   blink_phase,
  output logic [NUM_CHARS*GLYPH_W*GLYPH_H-1:0]   pixel_map
);

  localparam int LW = NUM_CHARS * GLYPH_W;
  localparam int GW = GLYPH_W * GLYPH_H;
  localparam int MW = LW * GLYPH_H;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_t;

  state_t           state;
  logic [KEY_W-1:0] buffer [NUM_CHARS];
  logic [AW-1:0]    idx;
  logic             dirty;
  logic [BW-1:0]    blink_cnt;
  logic [MW-1:0]    work_map;
  logic [GW-1:0]    glyph;
  logic             wr_ok;

  always_comb wr_ok = wr_en && (int'(wr_addr) < NUM_CHARS);

  // ROM address is combinational so the glyph lands in the same FETCH cycle.
  always_comb rom_key = (state == FETCH) ? buffer[idx] : BLANK_KEY;

  // idx never reaches an out-of-range hl_pos, so such positions never match.
  always_comb glyph = (hl_en && (hl_pos == idx) && blink_phase) ? ~rom_data : rom_data;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_CHARS; i++) buffer[i] <= BLANK_KEY;
      state       <= IDLE;
      idx         <= '0;
      dirty       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      blink_phase <= 1'b0;
      blink_cnt   <= '0;
      work_map    <= '0;
      pixel_map   <= '0;
    end else begin
      done <= 1'b0;
      if (wr_ok) buffer[wr_addr] <= wr_key;

      case (state)
        IDLE: begin
          // A write coinciding with start is caught by the fetch, so no dirty.
          if (start || dirty) begin
            state <= FETCH;
            idx   <= '0;
            busy  <= 1'b1;
            dirty <= 1'b0;
          end
        end

        FETCH: begin
          if (wr_ok) dirty <= 1'b1;
          for (int unsigned r = 0; r < GLYPH_H; r++) begin
            work_map[(GLYPH_H - r) * LW - 1 - 32'(idx) * GLYPH_W -: GLYPH_W]
              <= glyph[(GLYPH_H - r) * GLYPH_W - 1 -: GLYPH_W];
          end
          if (idx == AW'(NUM_CHARS - 1)) state <= COMMIT;
          else                           idx   <= idx + AW'(1);
        end

        COMMIT: begin
          if (wr_ok) dirty <= 1'b1;
          pixel_map <= work_map;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
          if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_line_renderer.sv
// Directed bench for text_line_renderer (NUM_CHARS=10, 12x12 glyphs, BLINK_FRAMES=2).
// The font ROM model returns row r of key k as {k,k,k}[14:3] ^ r.
module tb_text_line_renderer;

  localparam int NUM  = 10;
  localparam int GW   = 12;
  localparam int GH   = 12;
  localparam int KW   = 5;
  localparam int AW   = 4;
  localparam int LW   = NUM * GW;
  localparam int MAPW = LW * GH;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [KW-1:0]     wr_key = '0;
  logic              start = 1'b0;
  logic              hl_en = 1'b0;
  logic [AW-1:0]     hl_pos = '0;
  logic [KW-1:0]     rom_key;
  logic [GW*GH-1:0]  rom_data;
  logic              busy, done, blink_phase;
  logic [MAPW-1:0]   pixel_map;

  int total = 0;
  int bad   = 0;

  logic [KW-1:0]   exp_keys [NUM];
  logic [MAPW-1:0] prev_map;
  int              cnt;
  logic            ph_before;
  logic [4:0]      ph_after;

  text_line_renderer #(
    .NUM_CHARS(NUM), .GLYPH_W(GW), .GLYPH_H(GH), .KEY_W(KW),
    .BLANK_KEY(5'b11111), .BLINK_FRAMES(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key),
    .start(start), .hl_en(hl_en), .hl_pos(hl_pos), .rom_key(rom_key),
    .rom_data(rom_data), .busy(busy), .done(done), .blink_phase(blink_phase),
    .pixel_map(pixel_map)
  );

  always #5 Clk = ~Clk;

  function automatic logic [GW-1:0] row_pat(input logic [KW-1:0] k, input int r);
    logic [14:0] t;
    t = {k, k, k};
    return t[14:3] ^ 12'(r);
  endfunction

  always_comb begin
    rom_data = '0;
    for (int r = 0; r < GH; r++) rom_data[(GH - r) * GW - 1 -: GW] = row_pat(rom_key, r);
  end

  // Pixel-by-pixel expected map from exp_keys and an inversion mask.
  function automatic logic [MAPW-1:0] exp_map(input logic [NUM-1:0] inv);
    logic [MAPW-1:0] m;
    logic [GW-1:0]   p;
    m = '0;
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < NUM; c++) begin
        p = row_pat(exp_keys[c], r) ^ {GW{inv[c]}};
        for (int x = 0; x < GW; x++) m[(GH - r) * LW - 1 - c * GW - x] = p[GW - 1 - x];
      end
    return m;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_map(input string tag, input logic [MAPW-1:0] expv);
    int fr;
    total++;
    assert (pixel_map === expv) else begin
      bad++;
      fr = 0;
      for (int r = GH - 1; r >= 0; r--)
        if (pixel_map[(GH - r) * LW - 1 -: LW] !== expv[(GH - r) * LW - 1 -: LW]) fr = r;
      $error("FAIL %s: row %0d observed=%h expected=%h", tag, fr,
             pixel_map[(GH - fr) * LW - 1 -: LW], expv[(GH - fr) * LW - 1 -: LW]);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done === 1'b1) c++;
    end
  endtask

  task automatic write_slot(input logic [AW-1:0] a, input logic [KW-1:0] k);
    wr_en = 1'b1; wr_addr = a; wr_key = k;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    Reset = 1'b0;
    for (int i = 0; i < NUM; i++) exp_keys[i] = 5'b11111;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_blink", {31'd0, blink_phase}, 32'd0);
    chk("rst_rom_key", {27'd0, rom_key}, 32'h1f);
    chk_map("rst_map", '0);

    // First render: exact latency and blank glyphs
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy_first_fetch", {31'd0, busy}, 32'd1);
    for (int i = 0; i < NUM; i++) begin
      chk("t1_rom_key", {27'd0, rom_key}, {27'd0, exp_keys[i]});
      step();
    end
    chk("t1_busy_commit", {31'd0, busy}, 32'd1);
    chk("t1_done_commit", {31'd0, done}, 32'd0);
    chk_map("t1_map_before_done", '0);
    step();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk_map("t1_map_blank", exp_map('0));
    step();
    chk("t1_done_pulse_end", {31'd0, done}, 32'd0);

    // Single slot write
    write_slot(4'd5, 5'b01011);
    exp_keys[5] = 5'b01011;
    prev_map = pixel_map;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < NUM; i++) step();
    chk_map("t2_map_unchanged", prev_map);
    step();
    chk("t2_done", {31'd0, done}, 32'd1);
    chk_map("t2_map_slot5", exp_map('0));
    step();

    // Distinct keys; last write coincides with start
    for (int i = 0; i < NUM - 1; i++) begin
      write_slot(AW'(i), KW'(i * 3 + 1));
      exp_keys[i] = KW'(i * 3 + 1);
    end
    wr_en = 1'b1; wr_addr = 4'd9; wr_key = 5'd28; start = 1'b1;
    exp_keys[9] = 5'd28;
    step();
    wr_en = 1'b0; start = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      chk("t2b_rom_key_walk", {27'd0, rom_key}, {27'd0, exp_keys[i]});
      step();
    end
    step();
    chk("t2b_done", {31'd0, done}, 32'd1);
    chk_map("t2b_map_walk", exp_map('0));
    count_done(6, cnt);
    chk("t2b_no_dirty_rerender", cnt, 0);

    // Writes during render: slot 8 ahead of idx, slot 1 behind idx
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    wr_en = 1'b1; wr_addr = 4'd8; wr_key = 5'b00010;
    step();
    wr_addr = 4'd1; wr_key = 5'b10101;
    step();
    wr_en = 1'b0;
    exp_keys[8] = 5'b00010;
    wait_done("t3_done1");
    chk_map("t3_map_first", exp_map('0));
    exp_keys[1] = 5'b10101;
    step();
    chk("t3_auto_restart_busy", {31'd0, busy}, 32'd1);
    wait_done("t3_done2");
    chk_map("t3_map_second", exp_map('0));
    count_done(15, cnt);
    chk("t3_no_third_render", cnt, 0);

    // Out-of-range write, start while busy
    write_slot(4'd12, 5'b00000);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t6_done");
    chk_map("t6_map_oob_write", exp_map('0));
    count_done(15, cnt);
    chk("t6_start_busy_ignored", cnt, 0);
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);

    // Reset mid-render at idx 6
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_rom_key", {27'd0, rom_key}, 32'h1f);
    chk_map("t5_map_zero", '0);
    count_done(15, cnt);
    chk("t5_no_done", cnt, 0);
    for (int i = 0; i < NUM; i++) exp_keys[i] = 5'b11111;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t5_done_render");
    chk_map("t5_buffer_blank", exp_map('0));

    // Blink highlight on slot 2
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    write_slot(4'd2, 5'b00110);
    exp_keys[2] = 5'b00110;
    hl_en = 1'b1; hl_pos = 4'd2;
    ph_after = 5'b00110;  // phase after commits 1..5 = 0,1,1,0,0 (bit k = commit k+1)
    ph_before = 1'b0;
    for (int k = 0; k < 5; k++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("t4_done");
      chk("t4_blink_phase", {31'd0, blink_phase}, {31'd0, ph_after[k]});
      chk_map("t4_map_hl", exp_map(ph_before ? 10'b0000000100 : 10'b0));
      ph_before = ph_after[k];
    end
    // Out-of-range hl_pos: commit 6 sets phase 1, render 7 fetched with phase 1
    hl_pos = 4'd12;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t4_done6");
    chk("t4_blink_phase6", {31'd0, blink_phase}, 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t4_done7");
    chk_map("t4_map_hl_oob", exp_map('0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
